// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants, operation encodings, FSM state type and
// small op-decode helpers for the multiply/divide unit.
// Optional feature macro: MULDIV_MACC_EN (enables MADD/MADDU/MSUB/MSUBU).
package muldiv_pkg;

  localparam int unsigned MULDIV_DATA_WIDTH = 32;
  localparam int unsigned OP_WIDTH          = 3;

  localparam logic [OP_WIDTH-1:0] MULDIV_OP_MULT  = 3'd0;
  localparam logic [OP_WIDTH-1:0] MULDIV_OP_MULTU = 3'd1;
  localparam logic [OP_WIDTH-1:0] MULDIV_OP_DIV   = 3'd2;
  localparam logic [OP_WIDTH-1:0] MULDIV_OP_DIVU  = 3'd3;
  localparam logic [OP_WIDTH-1:0] MULDIV_OP_MADD  = 3'd4;
  localparam logic [OP_WIDTH-1:0] MULDIV_OP_MADDU = 3'd5;
  localparam logic [OP_WIDTH-1:0] MULDIV_OP_MSUB  = 3'd6;
  localparam logic [OP_WIDTH-1:0] MULDIV_OP_MSUBU = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
`ifdef MULDIV_MACC_EN
    S_ACC  = 3'd2,
`endif
    S_DIV  = 3'd3,
    S_FIX  = 3'd4,
    S_DONE = 3'd5
  } state_e;

  // Signed variants take two's-complement magnitudes
  function automatic logic op_signed(input logic [OP_WIDTH-1:0] op);
    return !(op == MULDIV_OP_MULTU || op == MULDIV_OP_DIVU ||
             op == MULDIV_OP_MADDU || op == MULDIV_OP_MSUBU);
  endfunction

  function automatic logic op_div(input logic [OP_WIDTH-1:0] op);
    return (op == MULDIV_OP_DIV) || (op == MULDIV_OP_DIVU);
  endfunction

  function automatic logic op_acc(input logic [OP_WIDTH-1:0] op);
    return (op == MULDIV_OP_MADD) || (op == MULDIV_OP_MADDU) ||
           (op == MULDIV_OP_MSUB) || (op == MULDIV_OP_MSUBU);
  endfunction

  function automatic logic op_sub(input logic [OP_WIDTH-1:0] op);
    return (op == MULDIV_OP_MSUB) || (op == MULDIV_OP_MSUBU);
  endfunction

  // Accumulate codes are only accepted when the accumulate path is built
  function automatic logic op_legal(input logic [OP_WIDTH-1:0] op);
    logic ok;
    ok = (op == MULDIV_OP_MULT) || (op == MULDIV_OP_MULTU) || op_div(op);
`ifdef MULDIV_MACC_EN
    ok = ok || op_acc(op);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: issue/result bundle between EX and the multiply/divide unit.
// master (EX side) drives start, op, opa, opb, acc_hi, acc_lo, annul;
// slave (unit side) drives stall_req, busy, done, hi, lo, div_by_zero.
interface muldiv_if #(
  parameter int unsigned W = muldiv_pkg::MULDIV_DATA_WIDTH
) ();

  logic                               start;
  logic [muldiv_pkg::OP_WIDTH-1:0]    op;
  logic [W-1:0]                       opa;
  logic [W-1:0]                       opb;
  logic [W-1:0]                       acc_hi;
  logic [W-1:0]                       acc_lo;
  logic                               annul;
  logic                               stall_req;
  logic                               busy;
  logic                               done;
  logic [W-1:0]                       hi;
  logic [W-1:0]                       lo;
  logic                               div_by_zero;

  modport master (
    output start, op, opa, opb, acc_hi, acc_lo, annul,
    input  stall_req, busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, opa, opb, acc_hi, acc_lo, annul,
    output stall_req, busy, done, hi, lo, div_by_zero
  );

endinterface

// File: rtl/muldiv_div_iter.sv
// muldiv_div_iter: restoring radix-2 unsigned divider, one quotient bit per
// cycle, MSB first. Ports: clk, rst_n (sync, active-low), start/annul
// control, dividend/divisor magnitudes in, done_c (combinational, high in
// the final iteration cycle), quo/rem registered results.
module muldiv_div_iter
  import muldiv_pkg::*;
#(
  parameter int unsigned W = MULDIV_DATA_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         annul,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done_c,
  output logic [W-1:0] quo,
  output logic [W-1:0] rem
);

  localparam int unsigned CW = $clog2(W);

  logic [CW-1:0] cnt;
  logic          run;
  logic [W-1:0]  dsr;
  logic [W:0]    shifted_c;
  logic [W:0]    trial_c;

  // Partial remainder needs one extra bit; a set MSB means the trial underflowed
  assign shifted_c = {rem, quo[W-1]};
  assign trial_c   = shifted_c - {1'b0, dsr};
  assign done_c    = run && (cnt == CW'(W-1));

  // Iteration: quo doubles as the dividend shift register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      run <= 1'b0;
      dsr <= '0;
      quo <= '0;
      rem <= '0;
    end else if (annul) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      cnt <= '0;
      run <= 1'b1;
      dsr <= divisor;
      quo <= dividend;
      rem <= '0;
    end else if (run) begin
      if (!trial_c[W]) begin
        rem <= trial_c[W-1:0];
        quo <= {quo[W-2:0], 1'b1};
      end else begin
        rem <= shifted_c[W-1:0];
        quo <= {quo[W-2:0], 1'b0};
      end
      cnt <= cnt + CW'(1);
      if (done_c) begin
        run <= 1'b0;
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit for the EX stage producing
// a HI/LO result pair. Ports: clk, rst_n (sync, active-low), bus
// (muldiv_if.slave: issue strobe, op, operands, forwarded HI/LO, annul in;
// stall request, busy, one-cycle done strobe, hi/lo, div_by_zero out).
// Optional feature macro: MULDIV_MACC_EN builds the multiply-accumulate
// ops and the ACC state; without it those op codes are ignored.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MULDIV_DATA_WIDTH
) (
  input logic      clk,
  input logic      rst_n,
  muldiv_if.slave  bus
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned DW = 2 * W;

  state_e        state;
  logic [W-1:0]  mag_a;
  logic [W-1:0]  mag_b;
  logic          neg_res;
  logic          neg_rem;

  logic          issue_c;
  logic          a_neg_c;
  logic          b_neg_c;
  logic [W-1:0]  a_mag_c;
  logic [W-1:0]  b_mag_c;
  logic          div_zero_c;
  logic          div_start_c;
  logic [DW-1:0] prod_c;
  logic [DW-1:0] prod_s_c;

  logic          div_done_c;
  logic [W-1:0]  div_quo;
  logic [W-1:0]  div_rem;

`ifdef MULDIV_MACC_EN
  logic          acc_op;
  logic          sub_op;
  logic [DW-1:0] acc;
  logic [DW-1:0] prod;
`else
  logic          unused_acc;
  assign unused_acc = ^{bus.acc_hi, bus.acc_lo};
`endif

  // Issue decode and operand magnitudes
  assign issue_c     = (state == S_IDLE) && bus.start && op_legal(bus.op) && !bus.annul;
  assign a_neg_c     = op_signed(bus.op) && bus.opa[W-1];
  assign b_neg_c     = op_signed(bus.op) && bus.opb[W-1];
  assign a_mag_c     = a_neg_c ? (~bus.opa + W'(1)) : bus.opa;
  assign b_mag_c     = b_neg_c ? (~bus.opb + W'(1)) : bus.opb;
  assign div_zero_c  = op_div(bus.op) && (bus.opb == '0);
  assign div_start_c = issue_c && op_div(bus.op) && !div_zero_c;

  // Hold the pipeline from issue until the result cycle
  assign bus.stall_req = issue_c || ((state != S_IDLE) && (state != S_DONE));

  // Magnitude product, signed result applied afterwards
  assign prod_c   = {{W{1'b0}}, mag_a} * {{W{1'b0}}, mag_b};
  assign prod_s_c = neg_res ? (~prod_c + DW'(1)) : prod_c;

  muldiv_div_iter #(.W(W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start_c),
    .annul    (bus.annul),
    .dividend (a_mag_c),
    .divisor  (b_mag_c),
    .done_c   (div_done_c),
    .quo      (div_quo),
    .rem      (div_rem)
  );

  // Sequencing FSM with registered result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      mag_a           <= '0;
      mag_b           <= '0;
      neg_res         <= 1'b0;
      neg_rem         <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.hi          <= '0;
      bus.lo          <= '0;
      bus.div_by_zero <= 1'b0;
`ifdef MULDIV_MACC_EN
      acc_op          <= 1'b0;
      sub_op          <= 1'b0;
      acc             <= '0;
      prod            <= '0;
`endif
    end else begin
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
      if (bus.annul) begin
        state    <= S_IDLE;
        bus.busy <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (issue_c) begin
              bus.busy <= 1'b1;
              mag_a    <= a_mag_c;
              mag_b    <= b_mag_c;
              neg_res  <= a_neg_c ^ b_neg_c;
              neg_rem  <= a_neg_c;
`ifdef MULDIV_MACC_EN
              acc_op   <= op_acc(bus.op);
              sub_op   <= op_sub(bus.op);
              acc      <= {bus.acc_hi, bus.acc_lo};
`endif
              if (div_zero_c) begin
                // Divide by zero: skip the divider, report immediately
                bus.hi          <= bus.opa;
                bus.lo          <= '1;
                bus.div_by_zero <= 1'b1;
                bus.done        <= 1'b1;
                state           <= S_DONE;
              end else if (op_div(bus.op)) begin
                state <= S_DIV;
              end else begin
                state <= S_MUL;
              end
            end
          end
          S_MUL: begin
`ifdef MULDIV_MACC_EN
            if (acc_op) begin
              prod  <= prod_s_c;
              state <= S_ACC;
            end else begin
              {bus.hi, bus.lo} <= prod_s_c;
              bus.done         <= 1'b1;
              state            <= S_DONE;
            end
`else
            {bus.hi, bus.lo} <= prod_s_c;
            bus.done         <= 1'b1;
            state            <= S_DONE;
`endif
          end
`ifdef MULDIV_MACC_EN
          S_ACC: begin
            {bus.hi, bus.lo} <= sub_op ? (acc - prod) : (acc + prod);
            bus.done         <= 1'b1;
            state            <= S_DONE;
          end
`endif
          S_DIV: begin
            if (div_done_c) state <= S_FIX;
          end
          S_FIX: begin
            // Quotient takes the sign product, remainder the dividend's sign
            bus.lo   <= neg_res ? (~div_quo + W'(1)) : div_quo;
            bus.hi   <= neg_rem ? (~div_rem + W'(1)) : div_rem;
            bus.done <= 1'b1;
            state    <= S_DONE;
          end
          S_DONE: begin
            bus.busy <= 1'b0;
            state    <= S_IDLE;
          end
          default: begin
            bus.busy <= 1'b0;
            state    <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit. A driver issues
// directed and random operations and queues the reference result with its
// due cycle; a monitor pops and compares on every done strobe.
// Honors MULDIV_MACC_EN to decide whether accumulate ops are legal.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

`ifdef MULDIV_MACC_EN
  localparam bit MACC = 1'b1;
`else
  localparam bit MACC = 1'b0;
`endif

  typedef struct {
    int unsigned due;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];

  muldiv_if #(.W(W)) bus ();

  muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain 64-bit / int arithmetic; returns op legality
  function automatic bit model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] h, input logic [31:0] l, output exp_t e);
    logic [63:0] p;
    logic [63:0] r;
    int          sa;
    int          sb;
    e.due = 0; e.hi = '0; e.lo = '0; e.dbz = 1'b0;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'd0, 3'd1: begin
        p = (op == 3'd0) ? 64'(longint'(sa) * longint'(sb)) : (64'(a) * 64'(b));
        {e.hi, e.lo} = p;
        e.due = 2;
      end
      3'd2, 3'd3: begin
        if (b == 0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = a; e.dbz = 1'b1; e.due = 1;
        end else begin
          e.due = W + 2;
          if (op == 3'd3) begin
            e.lo = a / b; e.hi = a % b;
          end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lo = 32'h8000_0000; e.hi = '0;
          end else begin
            e.lo = 32'(sa / sb); e.hi = 32'(sa % sb);
          end
        end
      end
      default: begin
        if (!MACC) return 1'b0;
        p = op[0] ? (64'(a) * 64'(b)) : 64'(longint'(sa) * longint'(sb));
        r = op[1] ? ({h, l} - p) : ({h, l} + p);
        {e.hi, e.lo} = r;
        e.due = 3;
      end
    endcase
    return 1'b1;
  endfunction

  // Issue one op; when tracked, also poke start mid-flight and wait for the result
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] h, input logic [31:0] l, input bit track, input bit with_annul);
    exp_t e;
    bit   legal;
    bit   live;
    int   n;
    @(negedge clk);
    bus.op = op; bus.opa = a; bus.opb = b; bus.acc_hi = h; bus.acc_lo = l;
    bus.start = 1'b1; bus.annul = with_annul;
    legal = model(op, a, b, h, l, e);
    live  = legal && !with_annul;
    e.due = e.due + cyc;
    #1;
    chk("stall_at_issue", 64'(bus.stall_req), 64'(live));
    if (track && live) exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0; bus.annul = 1'b0;
    chk("busy_after_issue", 64'(bus.busy), 64'(live));
    bus.opa = $urandom; bus.opb = $urandom; bus.acc_hi = $urandom; bus.acc_lo = $urandom;
    if (track && live) begin
      bus.op = 3'($urandom_range(0, 7));
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
        @(negedge clk);
        n++;
      end
      chk("result_drain", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  // Monitor: every done strobe must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got hi=%0h lo=%0h expected no strobe (cycle %0d)", bus.hi, bus.lo, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.due));
          chk("hi", 64'(bus.hi), 64'(e.hi));
          chk("lo", 64'(bus.lo), 64'(e.lo));
          chk("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
          chk("stall_in_done", 64'(bus.stall_req), 64'd0);
        end
      end else if (rst_n && bus.div_by_zero) begin
        checks++; errors++;
        $display("FAIL dbz_without_done: got 1 expected 0 (cycle %0d)", cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bus.start = 1'b0; bus.annul = 1'b0; bus.op = '0;
    bus.opa = '0; bus.opb = '0; bus.acc_hi = '0; bus.acc_lo = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.busy, bus.done, bus.div_by_zero, bus.stall_req, bus.hi[27:0], bus.lo}, 64'd0);
    rst_n = 1'b1;

    issue(MULDIV_OP_MULT, 32'hFFFF_FFFD, 32'd5, '0, '0, 1'b1, 1'b0);
    issue(MULDIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, '0, '0, 1'b1, 1'b0);
    issue(MULDIV_OP_DIVU, 32'd100, 32'd7, '0, '0, 1'b1, 1'b0);
    issue(MULDIV_OP_DIVU, 32'h1234, 32'd0, '0, '0, 1'b1, 1'b0);
    issue(MULDIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, '0, '0, 1'b1, 1'b0);
    issue(MULDIV_OP_DIV, 32'hFFFF_FF00, 32'd0, '0, '0, 1'b1, 1'b0);
    issue(MULDIV_OP_MADD, 32'd2, 32'd3, 32'd0, 32'h10, 1'b1, 1'b0);
    issue(MULDIV_OP_MSUB, 32'd2, 32'd3, 32'd0, 32'h10, 1'b1, 1'b0);
    issue(MULDIV_OP_MULTU, 32'd7, 32'd9, '0, '0, 1'b1, 1'b1);

    // Annul mid-divide, then a multiply two cycles later
    issue(MULDIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, '0, '0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    bus.annul = 1'b1;
    @(negedge clk);
    bus.annul = 1'b0;
    chk("annul_busy", 64'(bus.busy), 64'd0);
    chk("annul_stall", 64'(bus.stall_req), 64'd0);
    issue(MULDIV_OP_MULTU, 32'hFFFF_FFFF, 32'd2, '0, '0, 1'b1, 1'b0);

    // Reset in the middle of a divide
    issue(MULDIV_OP_DIV, 32'd12345, 32'd17, '0, '0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midop_reset_outputs", {bus.busy, bus.done, bus.div_by_zero, bus.stall_req, bus.hi[27:0], bus.lo}, 64'd0);
    chk("midop_reset_hi", 64'(bus.hi), 64'd0);
    rst_n = 1'b1;
    issue(MULDIV_OP_MULT, 32'h8000_0000, 32'h8000_0000, '0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 120; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        3: b = 32'(-int'($urandom_range(1, 9)));
        default: ;
      endcase
      issue(op, a, b, $urandom, $urandom, 1'b1, ($urandom_range(0, 15) == 0));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit for the EX stage. Parametrised in operand width. Executes signed/unsigned multiply, divide and (optionally) multiply-accumulate into the HI/LO pair. While an operation is in flight it holds the pipeline through a stall request, then presents a one-cycle result strobe for the HI/LO write path.

## Interface
- DATA_WIDTH, 32, operand width W; HI/LO are each W bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- start_i  in  1  issue strobe from EX; sampled only in IDLE.
- op_i  in  3  operation code: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU.
- opa_i  in  W  rs operand (multiplicand / dividend).
- opb_i  in  W  rt operand (multiplier / divisor).
- hi_i, lo_i  in  W each  current forwarded HI/LO; captured at start for accumulate ops.
- annul_i  in  1  flush; aborts any operation.
- stall_req_o  out  1  pipeline hold request.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle result strobe; doubles as HI/LO write enable.
- hi_o, lo_o  out  W each  result; valid when done_o=1, held otherwise.
- div_by_zero_o  out  1  pulses with done_o for a DIV/DIVU with opb=0.

## Operation
- States: IDLE, MUL, ACC, DIV, FIX, DONE.
- IDLE + start_i + legal op: capture operand magnitudes, sign flags, op, and {hi_i,lo_i}. Signed ops take two's-complement absolute values. Unsigned ops pass operands through. Next state:
  - MUL for multiply ops.
  - DIV for divide ops.
  - DONE for a divide with opb=0.
- MUL: 2W-bit product of magnitudes. Negated when the operand signs differ (signed ops only). Next state is ACC for accumulate ops, else DONE.
- ACC: MADD/MADDU computes {hi,lo}+product; MSUB/MSUBU computes {hi,lo}-product. Modulo 2^(2W). Next state DONE.
- DIV: restoring radix-2, one quotient bit per cycle, MSB first. A counter runs 0..W-1; at W-1 the next state is FIX.
- FIX: quotient is negated if the signs differ. Remainder takes the dividend's sign. Next state DONE.
- DONE: done_o=1. Multiply results: hi_o = upper W bits, lo_o = lower W bits. Divide results: lo_o = quotient, hi_o = remainder. Next state IDLE.
- Divide by zero: lo_o = all ones, hi_o = opa_i, div_by_zero_o=1.
- Signed overflow (most-negative / -1): lo_o = most-negative value, hi_o = 0. No flag.
- start_i outside IDLE is ignored. An illegal op in IDLE is ignored: no stall, no done.
- annul_i: next state is IDLE. No done_o is produced. annul_i has priority over start_i in the same cycle.
- rst_n low mid-operation: IDLE next edge, all outputs at their reset values.

## Timing
- Reset values: every output is 0; state is IDLE; the counter is 0.
- stall_req_o = (IDLE & start_i & legal op & !annul_i) | (state not in {IDLE, DONE}). It is combinational and deasserts in the DONE cycle so the issuing instruction advances with the result.
- Latency, counted from the start cycle (cycle 0) to the done_o cycle:
  - MULT/MULTU: 2.
  - MADD family: 3.
  - DIV/DIVU: W+2 (34 at W=32).
  - Divide by zero: 1.
- Back-to-back: a new start_i is accepted in the cycle after DONE (IDLE). It is not accepted in the DONE cycle itself.
- hi_o/lo_o are registered and hold their value until the next DONE.

## Configuration
- MULDIV_MACC_EN defined: MADD, MADDU, MSUB, MSUBU are legal and the ACC state exists.
- MULDIV_MACC_EN undefined:
  - These four codes are illegal and ignored.
  - hi_i/lo_i are unused.
  - The ACC state and the accumulator register are removed.

## Structure
- muldiv_pkg holds:
  - op_i encodings (MULDIV_OP_*).
  - the state enum.
  - DATA_WIDTH default constant.
- One sub-module, muldiv_div_iter. It holds the divide datapath: partial remainder, quotient shift register and iteration counter. It has start/annul inputs and a done output. The top FSM sequences it and applies signs in FIX.

## Test plan
- MULT opa=0xFFFFFFFD (-3), opb=5 -> done_o at cycle 2, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1; stall_req_o high in cycles 0-1.
- DIV opa=0xFFFFFFF9 (-7), opb=2 -> done_o at cycle 34, lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIVU 100/7 -> lo_o=14, hi_o=2.
- DIVU opa=0x1234, opb=0 -> done_o at cycle 1, lo_o=0xFFFFFFFF, hi_o=0x1234, div_by_zero_o=1.
- DIV started, annul_i at cycle 10 -> IDLE at cycle 11, no done_o. MULTU 0xFFFFFFFF*2 issued at cycle 12 -> hi_o=1, lo_o=0xFFFFFFFE at cycle 14.
- With MULDIV_MACC_EN: MADD hi_i=0, lo_i=0x10, opa=2, opb=3 -> done_o at cycle 3, lo_o=0x16, hi_o=0. MSUB with the same inputs -> lo_o=0xA. Without the macro: the same stimulus gives no stall_req_o and no done_o.
- rst_n low at DIV cycle 5 -> all outputs 0 the next cycle. MULT 0x80000000*0x80000000 afterwards -> hi_o=0x40000000, lo_o=0.
